time_keeper: RTL and testbench
==============================

Name: time_keeper

Overview:
- 24-hour BCD timekeeping core for the digital clock.
- Divides the system clock down to a 1 Hz tick and counts seconds, minutes and hours in packed BCD.
- Provides key-driven hour and minute adjustment with auto-repeat, plus hourly chime flags.
- Sits directly upstream of the alarm/bell stage, which consumes Hour, Minute and Second (8-bit packed BCD: [7:4] tens, [3:0] units) and the 1 Hz tick.

Parameters:
- CLK_HZ, 1000: CP frequency in Hz; the prescaler counts 0..CLK_HZ-1.
- HOLD_TICKS, 500: CP cycles an adjust key must stay held before auto-repeat starts.
- REPEAT_TICKS, 200: CP cycles between auto-repeat increments while the key stays held.

Ports:
- CP  input  1  system clock, rising edge; all state is in this single domain.
- CR  input  1  reset; synchronous, active-high.
- AdjHrKey  input  1  raw hour-adjust key, active-high, asynchronous to CP.
- AdjMinKey  input  1  raw minute-adjust key, active-high, asynchronous to CP.
- Hour  output  8  BCD hours, 00..23.
- Minute  output  8  BCD minutes, 00..59.
- Second  output  8  BCD seconds, 00..59.
- Tick1Hz  output  1  one-CP-cycle pulse when the prescaler wraps.
- ChimeLo  output  1  low-tone chime flag.
- ChimeHi  output  1  high-tone chime flag.

Behaviour:
- Reset: CR sampled high at a CP edge sets the following; CR has priority over all other events.
  - Hour=8'h00, Minute=8'h00, Second=8'h00.
  - Prescaler=0, Tick1Hz=0, ChimeLo=0, ChimeHi=0.
  - Both key synchronisers and both key FSMs return to IDLE.
- Prescaler: increments every CP cycle.
  - At CLK_HZ-1 it wraps to 0 and Tick1Hz is high for exactly that one cycle.
  - Tick1Hz is a registered output.
- Counting on Tick1Hz:
  - Second BCD increments; units 9->0 with tens carry.
  - Second 8'h59 -> 8'h00 generates a minute carry.
  - Minute follows the same rule; Minute 8'h59 -> 8'h00 generates an hour carry.
  - Hour 8'h23 -> 8'h00; 8'h09 -> 8'h10 and 8'h19 -> 8'h20.
  - A full cascade (23:59:59 -> 00:00:00) completes in one CP edge.
- Key inputs: each key passes through a 2-FF synchroniser, then a per-key FSM.
  - IDLE: synced key rises -> emit one increment pulse, go to HOLD, clear hold counter.
  - HOLD: key low -> IDLE. Hold counter reaches HOLD_TICKS-1 -> emit increment, go to REPEAT, clear counter.
  - REPEAT: key low -> IDLE. Counter reaches REPEAT_TICKS-1 -> emit increment, clear counter.
  - Latency: raw key rise to field change is 3 CP edges (2 sync + 1 edge detect/FSM).
- Minute increment (from key):
  - Minute+1 BCD, 59 -> 00 with no hour carry.
  - Second cleared to 00 and prescaler cleared to 0 in the same cycle.
- Hour increment (from key): Hour+1 BCD, 23 -> 00; Minute and Second are unaffected.
- Simultaneous events:
  - Minute key pulse and Tick1Hz on the same edge: the key wins. Second=00 and any minute carry from the tick is discarded.
  - Hour key pulse and an hour carry on the same edge: Hour advances by exactly 1.
  - Both keys pulsing on the same edge: both fields increment independently.
- Chime flags: combinational decode of the registered time, valid in the same cycle as the time value.
  - ChimeLo=1 when Minute=8'h59 and Second is one of 8'h51, 8'h53, 8'h55, 8'h57.
  - ChimeHi=1 when Minute=8'h59 and Second=8'h59.
  - Both flags are 0 at all other times.
- Outputs never hold non-BCD or out-of-range values; no illegal state is reachable.

Optional Feature:
- Macro: TIME_CHIME_EN.
- Defined: ChimeLo and ChimeHi behave as specified above.
- Undefined: ChimeLo and ChimeHi are tied to 0 and the chime decode logic is omitted. Ports are retained so the top-level wiring is unchanged.

Test Plan:
- CLK_HZ=4, CR high for 2 cycles then low -> all time outputs 00, Tick1Hz pulses every 4 CP cycles, Second reads 8'h01 after the first pulse.
- Reset state forced to 23:59:58, run 2 ticks -> 23:59:59 then 00:00:00 on a single edge; ChimeHi high during 59:59 only.
- From 00:00:00, 1-cycle AdjMinKey pulse -> Minute=8'h01, Second=8'h00, prescaler=0 on the 3rd CP edge after the key rise; Hour stays 8'h00.
- HOLD_TICKS=10, REPEAT_TICKS=4, AdjHrKey held for 30 cycles from Hour=8'h22 -> increments at t+3, t+13, t+17, t+21, t+25, t+29. Hour sequence: 23, 00, 01, 02, 03, 04; wraps without touching Minute.
- At Minute=8'h59, Second=8'h59, prescaler=CLK_HZ-1, AdjMinKey increment lands on the tick edge -> Minute=8'h00, Second=8'h00, Hour unchanged.
- Minute=8'h59, step Second through 8'h50..8'h58 -> ChimeLo high only at 51/53/55/57. With TIME_CHIME_EN undefined, both chime flags stay 0 throughout.

Source files
------------

// File: rtl/time_keeper.sv
// 24-hour packed-BCD timekeeper: 1 Hz prescaler, h/m/s counters, key adjust with auto-repeat.
// Optional hourly chime decode is compiled in when TIME_CHIME_EN is defined.

module time_keeper_key #(
  parameter int HOLD_TICKS   = 500,
  parameter int REPEAT_TICKS = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic inc_pulse
);

  localparam int CMAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX + 1) : 1;
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_TICKS - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sync1_q, sync2_q;
  logic           inc;

  // IDLE is only re-entered with the synced key low, so key high in IDLE is a rising edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    inc     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (sync2_q) begin
          inc     = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!sync2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          inc     = 1'b1;
          state_d = REPEAT;
          cnt_d   = '0;
        end
      end
      REPEAT: begin
        if (!sync2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == REPEAT_LAST) begin
          inc   = 1'b1;
          cnt_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign inc_pulse = inc;

endmodule

module time_keeper #(
  parameter int CLK_HZ       = 1000,
  parameter int HOLD_TICKS   = 500,
  parameter int REPEAT_TICKS = 200
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       AdjHrKey,
  input  logic       AdjMinKey,
  output logic [7:0] Hour,
  output logic [7:0] Minute,
  output logic [7:0] Second,
  output logic       Tick1Hz,
  output logic       ChimeLo,
  output logic       ChimeHi
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q, tick_d;
  logic [7:0]    sec_q, sec_d;
  logic [7:0]    min_q, min_d;
  logic [7:0]    hour_q, hour_d;
  logic          min_carry, hour_carry;
  logic          hr_inc, min_inc;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    if (v == last)
      return 8'h00;
    else if (v[3:0] == 4'h9)
      return {v[7:4] + 4'h1, 4'h0};
    else
      return {v[7:4], v[3:0] + 4'h1};
  endfunction

  time_keeper_key #(.HOLD_TICKS(HOLD_TICKS), .REPEAT_TICKS(REPEAT_TICKS)) u_hr_key (
    .clk       (CP),
    .rst       (CR),
    .key_raw   (AdjHrKey),
    .inc_pulse (hr_inc)
  );

  time_keeper_key #(.HOLD_TICKS(HOLD_TICKS), .REPEAT_TICKS(REPEAT_TICKS)) u_min_key (
    .clk       (CP),
    .rst       (CR),
    .key_raw   (AdjMinKey),
    .inc_pulse (min_inc)
  );

  // tick_q is high exactly while pre_q sits at its last value; the cascade fires on that edge.
  always_comb begin
    pre_d      = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    sec_d      = sec_q;
    min_d      = min_q;
    hour_d     = hour_q;
    min_carry  = 1'b0;
    hour_carry = 1'b0;

    if (tick_q) begin
      sec_d     = bcd_inc(sec_q, 8'h59);
      min_carry = (sec_q == 8'h59);
    end
    if (min_carry) begin
      min_d      = bcd_inc(min_q, 8'h59);
      hour_carry = (min_q == 8'h59);
    end
    // A minute key restarts the second and discards any carry from a coincident tick.
    if (min_inc) begin
      min_d      = bcd_inc(min_q, 8'h59);
      sec_d      = 8'h00;
      pre_d      = '0;
      hour_carry = 1'b0;
    end
    if (hour_carry || hr_inc)
      hour_d = bcd_inc(hour_q, 8'h23);

    tick_d = (pre_d == PRE_LAST);
  end

  always_ff @(posedge CP) begin
    if (CR) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
      sec_q  <= 8'h00;
      min_q  <= 8'h00;
      hour_q <= 8'h00;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
      sec_q  <= sec_d;
      min_q  <= min_d;
      hour_q <= hour_d;
    end
  end

  assign Hour    = hour_q;
  assign Minute  = min_q;
  assign Second  = sec_q;
  assign Tick1Hz = tick_q;

`ifdef TIME_CHIME_EN
  logic chime_lo, chime_hi;

  always_comb begin
    chime_lo = 1'b0;
    chime_hi = 1'b0;
    if (min_q == 8'h59) begin
      case (sec_q)
        8'h51, 8'h53, 8'h55, 8'h57: chime_lo = 1'b1;
        8'h59:                      chime_hi = 1'b1;
        default: ;
      endcase
    end
  end

  assign ChimeLo = chime_lo;
  assign ChimeHi = chime_hi;
`else
  assign ChimeLo = 1'b0;
  assign ChimeHi = 1'b0;
`endif

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper with a short prescaler and short key hold/repeat times.
module tb_time_keeper;

`ifdef TIME_CHIME_EN
  localparam logic CHIME = 1'b1;
`else
  localparam logic CHIME = 1'b0;
`endif

  logic       CP = 1'b0;
  logic       CR = 1'b1;
  logic       AdjHrKey = 1'b0;
  logic       AdjMinKey = 1'b0;
  logic [7:0] Hour, Minute, Second;
  logic       Tick1Hz, ChimeLo, ChimeHi;

  int checks = 0;
  int errors = 0;

  time_keeper #(.CLK_HZ(4), .HOLD_TICKS(10), .REPEAT_TICKS(4)) dut (
    .CP        (CP),
    .CR        (CR),
    .AdjHrKey  (AdjHrKey),
    .AdjMinKey (AdjMinKey),
    .Hour      (Hour),
    .Minute    (Minute),
    .Second    (Second),
    .Tick1Hz   (Tick1Hz),
    .ChimeLo   (ChimeLo),
    .ChimeHi   (ChimeHi)
  );

  always #5 CP = ~CP;

  task automatic step(input int n);
    repeat (n) @(posedge CP);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_time(input string tag, input logic [7:0] h, input logic [7:0] m,
                          input logic [7:0] s);
    chk({tag, "_hour"}, Hour, h);
    chk({tag, "_min"}, Minute, m);
    chk({tag, "_sec"}, Second, s);
  endtask

  // One-cycle key press; the increment lands on the 3rd edge, task returns after the 5th.
  task automatic press(input logic hr, input logic mn);
    AdjHrKey  = hr;
    AdjMinKey = mn;
    step(1);
    AdjHrKey  = 1'b0;
    AdjMinKey = 1'b0;
    step(4);
  endtask

  initial begin
    // Reset
    step(2);
    chk_time("rst", 8'h00, 8'h00, 8'h00);
    chk("rst_tick", {7'd0, Tick1Hz}, 8'd0);
    chk("rst_lo", {7'd0, ChimeLo}, 8'd0);
    chk("rst_hi", {7'd0, ChimeHi}, 8'd0);
    CR = 1'b0;

    // Prescaler: tick on 3rd edge after reset release, Second increments on the 4th
    step(2);
    chk("pre_tick_e2", {7'd0, Tick1Hz}, 8'd0);
    step(1);
    chk("pre_tick_e3", {7'd0, Tick1Hz}, 8'd1);
    chk("pre_sec_e3", Second, 8'h00);
    step(1);
    chk("pre_tick_e4", {7'd0, Tick1Hz}, 8'd0);
    chk("pre_sec_e4", Second, 8'h01);
    step(3);
    chk("pre_tick_e7", {7'd0, Tick1Hz}, 8'd1);
    step(1);
    chk("pre_sec_e8", Second, 8'h02);

    // Single minute key pulse: lands on 3rd edge, clears second and prescaler
    AdjMinKey = 1'b1;
    step(1);
    AdjMinKey = 1'b0;
    step(1);
    chk("mkey_e2_min", Minute, 8'h00);
    step(1);
    chk_time("mkey_e3", 8'h00, 8'h01, 8'h00);
    chk("mkey_e3_tick", {7'd0, Tick1Hz}, 8'd0);
    step(2);
    chk("mkey_e5_tick", {7'd0, Tick1Hz}, 8'd0);
    step(1);
    chk("mkey_e6_tick", {7'd0, Tick1Hz}, 8'd1);
    step(1);
    chk("mkey_e7_sec", Second, 8'h01);

    // Hour to 22 by short presses
    for (int i = 0; i < 22; i++) press(1'b1, 1'b0);
    chk("pre_hold_hour", Hour, 8'h22);
    chk("pre_hold_min", Minute, 8'h01);

    // Held hour key: increments at t+3, +13, +17, +21, +25, +29
    AdjHrKey = 1'b1;
    step(2);
    chk("hold_t2", Hour, 8'h22);
    step(1);
    chk("hold_t3", Hour, 8'h23);
    step(9);
    chk("hold_t12", Hour, 8'h23);
    step(1);
    chk("hold_t13", Hour, 8'h00);
    step(3);
    chk("hold_t16", Hour, 8'h00);
    step(1);
    chk("hold_t17", Hour, 8'h01);
    step(4);
    chk("hold_t21", Hour, 8'h02);
    step(4);
    chk("hold_t25", Hour, 8'h03);
    step(4);
    chk("hold_t29", Hour, 8'h04);
    step(1);
    AdjHrKey = 1'b0;
    step(3);
    chk("hold_t33", Hour, 8'h04);
    step(4);
    chk("hold_t37", Hour, 8'h04);
    chk("hold_min", Minute, 8'h01);

    // Set 23:59:00, then run up to 23:59:58
    press(1'b0, 1'b1);
    for (int i = 0; i < 19; i++) press(1'b1, 1'b0);
    for (int i = 0; i < 57; i++) press(1'b0, 1'b1);
    chk_time("set_2359", 8'h23, 8'h59, 8'h00);
    step(230);
    chk_time("at_58", 8'h23, 8'h59, 8'h58);
    chk("at_58_lo", {7'd0, ChimeLo}, 8'd0);
    chk("at_58_hi", {7'd0, ChimeHi}, 8'd0);
    step(3);
    chk("at_58_tick", {7'd0, Tick1Hz}, 8'd1);
    step(1);
    chk_time("at_59", 8'h23, 8'h59, 8'h59);
    chk("at_59_hi", {7'd0, ChimeHi}, {7'd0, CHIME});
    chk("at_59_lo", {7'd0, ChimeLo}, 8'd0);
    step(3);
    chk("at_59_tick", {7'd0, Tick1Hz}, 8'd1);
    chk("at_59_hi_late", {7'd0, ChimeHi}, {7'd0, CHIME});
    step(1);
    chk_time("wrap", 8'h00, 8'h00, 8'h00);
    chk("wrap_hi", {7'd0, ChimeHi}, 8'd0);

    // Low chime sweep over 59:50..59:58
    for (int i = 0; i < 59; i++) press(1'b0, 1'b1);
    step(198);
    for (int k = 0; k < 9; k++) begin
      chk("sweep_sec", Second, 8'h50 + 8'(k));
      chk("sweep_lo", {7'd0, ChimeLo}, {7'd0, CHIME & (k % 2 == 1)});
      chk("sweep_hi", {7'd0, ChimeHi}, 8'd0);
      if (k < 8) step(4);
    end
    chk("sweep_min", Minute, 8'h59);

    // Minute key landing on the 59:59 tick edge: no hour carry
    step(4);
    chk("coin_sec59", Second, 8'h59);
    step(1);
    AdjMinKey = 1'b1;
    step(1);
    AdjMinKey = 1'b0;
    step(1);
    chk("coin_tick", {7'd0, Tick1Hz}, 8'd1);
    step(1);
    chk_time("coin", 8'h00, 8'h00, 8'h00);
    chk("coin_tick_clr", {7'd0, Tick1Hz}, 8'd0);
    step(2);

    // Both keys on the same edge
    press(1'b1, 1'b1);
    chk_time("both", 8'h01, 8'h01, 8'h00);

    // Hour key on the same edge as an hour carry: +1 only
    for (int i = 0; i < 58; i++) press(1'b0, 1'b1);
    step(234);
    chk_time("hc_pre", 8'h01, 8'h59, 8'h59);
    step(1);
    AdjHrKey = 1'b1;
    step(1);
    AdjHrKey = 1'b0;
    step(1);
    chk("hc_tick", {7'd0, Tick1Hz}, 8'd1);
    chk("hc_hour_before", Hour, 8'h01);
    step(1);
    chk_time("hc", 8'h02, 8'h00, 8'h00);

    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
